// File: rtl/keypad_pkg.sv
// Shared encodings for the keypad scanner: debounce states, frame results and the key map.
// Pure declarations; no timing or flow control of its own.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAND,
        ST_PRESSED,
        ST_REL_CHK
    } kp_state_t;

    typedef enum logic [1:0] {
        FR_NONE,
        FR_ONE,
        FR_MULTI
    } frame_kind_t;

    // Board legend, row-major: r0 1 2 3 A | r1 4 5 6 B | r2 7 8 9 C | r3 E 0 F D
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = 4'hE;
            4'd13:   code = 4'h0;
            4'd14:   code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_col_scanner.sv
// Walks a low bit across the keypad columns and classifies each 4-column frame as NONE/ONE/MULTI.
// Frame result is combinational on the frame-end cycle (frameDone); free-running, no backpressure.
module keypad_col_scanner
    import keypad_pkg::*;
#(
    parameter int COL_DWELL_CYCLES = 27000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] kpRows,
    output logic [3:0] kpCols,
    output logic       frameDone,
    output logic [1:0] frameKind,
    output logic [3:0] frameCode
);

    localparam int DW = (COL_DWELL_CYCLES > 1) ? $clog2(COL_DWELL_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(COL_DWELL_CYCLES - 1);

    logic [3:0]    rows_meta;
    logic [3:0]    rows_sync;
    logic [DW-1:0] dwell;
    logic [1:0]    col;
    logic [1:0]    acc_hits;
    logic [3:0]    acc_code;
    logic          dwell_end;
    logic [1:0]    tot_hits;
    logic [3:0]    tot_code;

    assign dwell_end = (dwell == DWELL_LAST);
    assign kpCols    = ~(4'b0001 << col);

    // Hit count saturates at 2: anything beyond one key is simply MULTI.
    always_comb begin
        tot_hits = acc_hits;
        tot_code = acc_code;
        for (int r = 0; r < 4; r++) begin
            if (!rows_sync[r]) begin
                if (tot_hits == 2'd0) begin
                    tot_code = key_code(2'(r), col);
                end
                if (tot_hits != 2'd2) begin
                    tot_hits = tot_hits + 2'd1;
                end
            end
        end
        frameDone = dwell_end && (col == 2'd3);
        frameCode = tot_code;
        if (tot_hits == 2'd0) begin
            frameKind = FR_NONE;
        end else if (tot_hits == 2'd1) begin
            frameKind = FR_ONE;
        end else begin
            frameKind = FR_MULTI;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rows_meta <= 4'hF;
            rows_sync <= 4'hF;
            dwell     <= '0;
            col       <= 2'd0;
            acc_hits  <= 2'd0;
            acc_code  <= 4'h0;
        end else begin
            rows_meta <= kpRows;
            rows_sync <= rows_meta;
            if (dwell_end) begin
                dwell <= '0;
                col   <= col + 2'd1;
                if (col == 2'd3) begin
                    acc_hits <= 2'd0;
                    acc_code <= 4'h0;
                end else begin
                    acc_hits <= tot_hits;
                    acc_code <= tot_code;
                end
            end else begin
                dwell <= dwell + DW'(1);
            end
        end
    end

endmodule

// File: rtl/keypad_hex_entry.sv
// Debounces keypad frames into one keyValid pulse per press and shifts hex digits into entryValue.
// keyValid lands 1 clk after the completing frame end; no backpressure, events are pulses.
module keypad_hex_entry
    import keypad_pkg::*;
#(
    parameter int COL_DWELL_CYCLES = 27000,
    parameter int DEBOUNCE_FRAMES  = 5
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  kpCols,
    input  logic [3:0]  kpRows,
    input  logic        clearEntry,
    output logic [3:0]  keyCode,
    output logic        keyValid,
    output logic        keyHeld,
    output logic [15:0] entryValue
);

    // One extra bit so a power-of-two frame count still fits at saturation.
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_FRAMES);

    kp_state_t   state, state_n;
    logic [3:0]  cand, cand_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic        fire;
    logic        release_done;
    logic        frameDone;
    logic [1:0]  frameKind;
    logic [3:0]  frameCode;

    keypad_col_scanner #(
        .COL_DWELL_CYCLES(COL_DWELL_CYCLES)
    ) u_scan (
        .clk       (clk),
        .rst       (rst),
        .kpRows    (kpRows),
        .kpCols    (kpCols),
        .frameDone (frameDone),
        .frameKind (frameKind),
        .frameCode (frameCode)
    );

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

    always_comb begin
        state_n      = state;
        cand_n       = cand;
        cnt_n        = cnt;
        fire         = 1'b0;
        release_done = 1'b0;
        if (frameDone) begin
            case (state)
                ST_IDLE: begin
                    if (frameKind == FR_ONE) begin
                        state_n = ST_CAND;
                        cand_n  = frameCode;
                        cnt_n   = CW'(1);
                    end
                end
                ST_CAND: begin
                    if (frameKind == FR_ONE && frameCode == cand) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            state_n = ST_PRESSED;
                            fire    = 1'b1;
                        end
                    end else if (frameKind == FR_ONE) begin
                        cand_n = frameCode;
                        cnt_n  = CW'(1);
                    end else begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end
                end
                ST_PRESSED: begin
                    if (frameKind == FR_NONE) begin
                        state_n = ST_REL_CHK;
                        cnt_n   = CW'(1);
                    end
                end
                ST_REL_CHK: begin
                    if (frameKind == FR_NONE) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            state_n      = ST_IDLE;
                            cnt_n        = '0;
                            release_done = 1'b1;
                        end
                    end else begin
                        state_n = ST_PRESSED;
                        cnt_n   = '0;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cand       <= 4'h0;
            cnt        <= '0;
            keyCode    <= 4'h0;
            keyValid   <= 1'b0;
            keyHeld    <= 1'b0;
            entryValue <= 16'h0000;
        end else begin
            state    <= state_n;
            cand     <= cand_n;
            cnt      <= cnt_n;
            keyValid <= fire;
            if (fire) begin
                keyCode <= cand;
            end
            if (fire) begin
                keyHeld <= 1'b1;
            end else if (release_done) begin
                keyHeld <= 1'b0;
            end
            // A clear on the keyValid cycle drops that digit.
            if (clearEntry) begin
                entryValue <= 16'h0000;
            end else if (keyValid) begin
                entryValue <= {entryValue[11:0], keyCode};
            end
        end
    end

endmodule

// File: tb/tb_keypad_hex_entry.sv
// Scoreboard bench for keypad_hex_entry: per-frame key sets drive a keypad model and a run-length reference.
// A negedge monitor pops expected events on keyValid and checks code, cycle and resulting entry.
module tb_keypad_hex_entry;

    localparam int DWELL = 4;
    localparam int DF    = 3;
    localparam int FRAME = 4 * DWELL;

    localparam logic [3:0] KEYS [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                         4'h4, 4'h5, 4'h6, 4'hB,
                                         4'h7, 4'h8, 4'h9, 4'hC,
                                         4'hE, 4'h0, 4'hF, 4'hD};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  kpCols;
    logic [3:0]  kpRows;
    logic        clearEntry = 1'b0;
    logic [3:0]  keyCode;
    logic        keyValid;
    logic        keyHeld;
    logic [15:0] entryValue;
    logic [15:0] pressed = 16'h0000;

    always #5 clk = ~clk;

    keypad_hex_entry #(
        .COL_DWELL_CYCLES(DWELL),
        .DEBOUNCE_FRAMES (DF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .kpCols     (kpCols),
        .kpRows     (kpRows),
        .clearEntry (clearEntry),
        .keyCode    (keyCode),
        .keyValid   (keyValid),
        .keyHeld    (keyHeld),
        .entryValue (entryValue)
    );

    // Matrix: a pressed switch pulls its row low while its column is driven low.
    always_comb begin
        kpRows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !kpCols[c]) kpRows[r] = 1'b0;
            end
        end
    end

    typedef struct {
        logic [3:0]  code;
        int          cyc;
        logic [15:0] entry;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model state: whole-frame run lengths.
    bit          held;
    int          run;
    int          relrun;
    logic [3:0]  runkey;
    logic [15:0] entry_m;
    int          fidx;
    bit          clr_pend;

    task automatic model_reset();
        held = 0; run = 0; relrun = 0; runkey = 4'h0;
        entry_m = 16'h0; fidx = 0; clr_pend = 0;
    endtask

    task automatic model_frame(input logic [15:0] m, input bit clr);
        int n;
        logic [3:0] code;
        n = $countones(m);
        code = 4'h0;
        for (int i = 0; i < 16; i++) if (m[i]) code = KEYS[i];
        if (!held) begin
            if (n == 1) begin
                if (run > 0 && code == runkey) run++;
                else begin runkey = code; run = 1; end
                if (run == DF) begin
                    held = 1; run = 0; relrun = 0;
                    entry_m = clr ? 16'h0 : {entry_m[11:0], code};
                    sb.push_back('{code, FRAME * fidx + FRAME, entry_m});
                    clr_pend = clr;
                end
            end else begin
                run = 0;
            end
        end else begin
            if (n == 0) begin
                relrun++;
                if (relrun == DF) begin held = 0; relrun = 0; end
            end else begin
                relrun = 0;
            end
        end
    endtask

    task automatic run_frames(input logic [15:0] m, input int nf, input bit clr);
        for (int f = 0; f < nf; f++) begin
            pressed = m;
            model_frame(m, clr);
            for (int i = 0; i < FRAME; i++) begin
                @(posedge clk);
                #1;
                clearEntry = 1'b0;
            end
            check("keyHeld", 32'(keyHeld), 32'(held));
            if (clr_pend) begin
                clearEntry = 1'b1;
                clr_pend = 0;
            end
            fidx++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clearEntry = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_kpCols", 32'(kpCols), 32'h0000_000E);
        check("reset_keyCode", 32'(keyCode), 32'h0);
        check("reset_keyValid", 32'(keyValid), 32'h0);
        check("reset_keyHeld", 32'(keyHeld), 32'h0);
        check("reset_entryValue", 32'(entryValue), 32'h0);
        check("sb_empty_at_reset", 32'(sb.size()), 32'h0);
        sb.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: column walk every cycle, events against the scoreboard, entry one cycle later.
    logic [15:0] pend_entry;
    bit          pend_chk = 0;
    logic [3:0]  exp_cols;
    exp_t        e;

    always @(negedge clk) begin
        if (rst) begin
            pend_chk = 0;
        end else begin
            exp_cols = ~(4'b0001 << ((cyc / DWELL) % 4));
            check("kpCols", 32'(kpCols), 32'(exp_cols));
            if (pend_chk) begin
                check("entryValue_after_event", 32'(entryValue), 32'(pend_entry));
                pend_chk = 0;
            end
            if (keyValid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_keyValid actual=code %0h required=no event (t=%0t)", keyCode, $time);
                end else begin
                    e = sb.pop_front();
                    check("keyCode", 32'(keyCode), 32'(e.code));
                    check("keyValid_cycle", 32'(cyc), 32'(e.cyc));
                    pend_entry = e.entry;
                    pend_chk = 1;
                end
            end
        end
    end

    function automatic logic [15:0] km(input int idx);
        logic [15:0] m;
        m = 16'h0;
        m[idx] = 1'b1;
        return m;
    endfunction

    initial begin
        int a;
        int b;
        logic [15:0] m;
        model_reset();
        do_reset();

        // '5' (r1c1) held 10 frames, then released
        run_frames(km(5), 10, 0);
        run_frames(16'h0, 4, 0);
        check("t1_entry", 32'(entryValue), 32'h0005);

        // 1,2,3,4,5 with gaps
        run_frames(km(0), 4, 0); run_frames(16'h0, 4, 0);
        run_frames(km(1), 4, 0); run_frames(16'h0, 4, 0);
        run_frames(km(2), 4, 0); run_frames(16'h0, 4, 0);
        run_frames(km(4), 4, 0); run_frames(16'h0, 4, 0);
        run_frames(km(5), 4, 0); run_frames(16'h0, 4, 0);
        check("t2_entry", 32'(entryValue), 32'h2345);

        // '7' bouncing, then held steady
        run_frames(km(8), 2, 0); run_frames(16'h0, 1, 0);
        run_frames(km(8), 2, 0); run_frames(16'h0, 2, 0);
        check("t3_no_event_entry", 32'(entryValue), 32'h2345);
        run_frames(km(8), 3, 0); run_frames(16'h0, 4, 0);
        check("t3_keyCode", 32'(keyCode), 32'h7);
        check("t3_entry", 32'(entryValue), 32'h3457);

        // two keys in one row together
        run_frames(km(0) | km(1), 8, 0);
        run_frames(16'h0, 2, 0);
        check("t4_entry", 32'(entryValue), 32'h3457);

        // clear on the keyValid cycle of 'A' from 1234
        do_reset();
        run_frames(km(0), 3, 0); run_frames(16'h0, 3, 0);
        run_frames(km(1), 3, 0); run_frames(16'h0, 3, 0);
        run_frames(km(2), 3, 0); run_frames(16'h0, 3, 0);
        run_frames(km(4), 3, 0); run_frames(16'h0, 3, 0);
        check("t5_pre_entry", 32'(entryValue), 32'h1234);
        run_frames(km(3), 3, 1); run_frames(16'h0, 4, 0);
        check("t5_entry", 32'(entryValue), 32'h0);
        check("t5_keyCode", 32'(keyCode), 32'hA);

        // reset while 'F' is held, key stays down across reset
        run_frames(km(14), 5, 0);
        do_reset();
        run_frames(km(14), 4, 0);
        run_frames(16'h0, 4, 0);
        check("t6_keyCode", 32'(keyCode), 32'hF);
        check("t6_entry", 32'(entryValue), 32'h000F);

        // randomized presses, holds, gaps, multi-key frames and clears
        for (int it = 0; it < 40; it++) begin
            a = $urandom_range(0, 15);
            m = km(a);
            if ($urandom_range(0, 9) == 0) begin
                b = (a + 1 + $urandom_range(0, 14)) % 16;
                m = m | km(b);
            end
            run_frames(m, $urandom_range(1, 6), ($urandom_range(0, 7) == 0));
            run_frames(16'h0, $urandom_range(0, 4), 0);
        end

        run_frames(16'h0, 4, 0);
        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
